// File: rtl/data_cache.sv
// data_cache -- direct-mapped, write-through, no-allocate data cache with an
// internal backing store of 2^NBITS bytes and a fixed MEMLAT-cycle access.
//
// Ports
//   clock      in   single clock, all state on the rising edge
//   reset      in   asynchronous active-high reset (backing store untouched)
//   Address    in   byte address; low log2(NLINES) bits index, rest is tag
//   WriteData  in   store data
//   MemRead    in   load request, held with Address while busy
//   MemWrite   in   store request, held with Address/WriteData while busy;
//                   wins over MemRead when both are set
//   ReadData   out  line data on a hit, otherwise 0
//   busy       out  stall; requester must not advance while set
//   hit        out  combinational tag match on the addressed line
module data_cache #(
    parameter int NBITS  = 8,
    parameter int NLINES = 8,
    parameter int MEMLAT = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-1:0] Address,
    input  logic [NBITS-1:0] WriteData,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [NBITS-1:0] ReadData,
    output logic             busy,
    output logic             hit
);

    localparam int IDXW  = $clog2(NLINES);
    localparam int TAGW  = NBITS - IDXW;
    localparam int CNTW  = $clog2(MEMLAT) + 1;
    localparam int MEMSZ = 1 << NBITS;
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(MEMLAT - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [NBITS-1:0]  addr_q, addr_d;
    logic [NBITS-1:0]  wdata_q, wdata_d;

    logic [NLINES-1:0]            valid_q;
    logic [NLINES-1:0][TAGW-1:0]  tag_q;
    logic [NLINES-1:0][NBITS-1:0] data_q;

    // Backing store: zero at power-up, deliberately outside the reset domain.
    logic [NBITS-1:0] mem_q [MEMSZ] = '{default: '0};

    logic             fill_commit;
    logic             wr_commit;

    logic [IDXW-1:0]  idx;
    logic [TAGW-1:0]  tag;
    logic [IDXW-1:0]  wr_idx;
    logic [TAGW-1:0]  wr_tag;

    assign idx    = Address[IDXW-1:0];
    assign tag    = Address[NBITS-1:IDXW];
    assign wr_idx = addr_q[IDXW-1:0];
    assign wr_tag = addr_q[NBITS-1:IDXW];

    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign ReadData = hit ? data_q[idx] : '0;

    // Next-state / outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy        = 1'b0;
        fill_commit = 1'b0;
        wr_commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    busy    = 1'b1;
                    state_d = WRITE;
                    cnt_d   = CNT_INIT;
                    addr_d  = Address;
                    wdata_d = WriteData;
                end else if (MemRead && !hit) begin
                    busy    = 1'b1;
                    state_d = FILL;
                    cnt_d   = CNT_INIT;
                end
            end
            FILL: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    // Address is held by the requester, so the fill reads it live.
                    fill_commit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    wr_commit = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // Request still held here was the one just serviced: ignore it.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Cache lines: fill overwrites unconditionally; a store only refreshes
    // a line already holding that address (no allocate on write).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_commit) begin
            valid_q[idx] <= 1'b1;
            tag_q[idx]   <= tag;
            data_q[idx]  <= mem_q[Address];
        end else if (wr_commit && valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag)) begin
            data_q[wr_idx] <= wdata_q;
        end
    end

    // Reset forces IDLE, so an aborted store never reaches this write.
    always_ff @(posedge clock) begin
        if (wr_commit) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    localparam int NB   = 8;
    localparam int NL   = 8;
    localparam int ML   = 3;
    localparam int MAXC = 20;

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] Address, WriteData, ReadData;
    logic          MemRead, MemWrite, busy, hit;

    data_cache #(.NBITS(NB), .NLINES(NL), .MEMLAT(ML)) dut (
        .clock(clock), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData),
        .busy(busy), .hit(hit)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    // Reference: flat memory plus, per line, which full address it holds.
    logic [NB-1:0] m_mem [256];
    bit            m_v   [NL];
    logic [NB-1:0] m_a   [NL];
    logic [NB-1:0] m_d   [NL];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_clear_lines();
        for (int i = 0; i < NL; i++) begin
            m_v[i] = 0; m_a[i] = '0; m_d[i] = '0;
        end
    endfunction

    task automatic do_read(input logic [NB-1:0] a);
        int  n;
        int  ix;
        bit  eh;
        ix = a % NL;
        eh = m_v[ix] && (m_a[ix] == a);
        @(negedge clock);
        MemRead = 1'b1; MemWrite = 1'b0; Address = a;
        #1;
        chk("rd_hit_first", hit, eh);
        n = 0;
        while (busy === 1'b1 && n < MAXC) begin
            n++;
            chk("rd_no_early_hit", hit, 0);
            @(negedge clock); #1;
        end
        chk("rd_busy_cycles", n, eh ? 0 : ML + 1);
        if (!eh) begin
            m_v[ix] = 1; m_a[ix] = a; m_d[ix] = m_mem[a];
        end
        chk("rd_hit_after", hit, 1);
        chk("rd_data", ReadData, m_d[ix]);
    endtask

    task automatic do_write(input logic [NB-1:0] a, input logic [NB-1:0] d, input bit rd);
        int n;
        int ix;
        ix = a % NL;
        @(negedge clock);
        MemWrite = 1'b1; MemRead = rd; Address = a; WriteData = d;
        #1;
        n = 0;
        while (busy === 1'b1 && n < MAXC) begin
            n++;
            @(negedge clock); #1;
        end
        chk("wr_busy_cycles", n, ML + 1);
        m_mem[a] = d;
        if (m_v[ix] && m_a[ix] == a) m_d[ix] = d;
        // One DONE cycle with the request still present, then idle.
        @(negedge clock);
        MemWrite = 1'b0; MemRead = 1'b0;
        #1;
        chk("wr_idle_after_done", busy, 0);
    endtask

    task automatic abort_write(input logic [NB-1:0] a, input logic [NB-1:0] d);
        @(negedge clock);
        MemWrite = 1'b1; MemRead = 1'b0; Address = a; WriteData = d;
        #1;
        chk("ab_busy_start", busy, 1);
        @(negedge clock); #1;
        reset = 1'b1; MemWrite = 1'b0;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_hit", hit, 0);
        chk("ab_rdata", ReadData, 0);
        m_clear_lines();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        m_clear_lines();
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        Address = 8'h15; WriteData = '0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_hit", hit, 0);
        chk("rst_rdata", ReadData, 0);
        @(negedge clock);
        reset = 1'b0;

        do_read(8'h15);
        do_write(8'h15, 8'hA5, 1'b0);
        do_read(8'h15);
        do_read(8'h1D);
        do_read(8'h15);
        abort_write(8'h22, 8'h77);
        do_read(8'h22);
        do_write(8'h30, 8'h5C, 1'b1);
        do_read(8'h30);
        // Distinct lines, then back-to-back hits.
        do_read(8'h15);
        do_read(8'h0E);
        do_read(8'h15);
        do_read(8'h0E);
        // Write to a non-resident address must not allocate.
        do_write(8'h26, 8'h3C, 1'b0);
        do_read(8'h26);

        for (int k = 0; k < 300; k++) begin
            logic [NB-1:0] a, d;
            int op;
            a  = NB'($urandom_range(0, 31));
            d  = NB'($urandom);
            op = int'($urandom_range(0, 19));
            if (op == 0)       abort_write(a, d);
            else if (op < 8)   do_write(a, d, bit'($urandom_range(0, 1)));
            else               do_read(a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
